// File: rtl/sipo_frame_collector_if.sv
// sipo_frame_collector_if: serial input, frame output and status bundle for the SIPO frame collector
interface sipo_frame_collector_if #(parameter int WIDTH = 4);
    logic                     serial_in;
    logic                     in_valid;
    logic                     sync;
    logic                     out_ready;
    logic                     clr_overrun;
    logic [WIDTH-1:0]         parallel_out;
    logic                     out_valid;
    logic                     overrun;
    logic [$clog2(WIDTH):0]   bit_count;
    modport master (
        output serial_in, in_valid, sync, out_ready, clr_overrun,
        input  parallel_out, out_valid, overrun, bit_count
    );
    modport slave (
        input  serial_in, in_valid, sync, out_ready, clr_overrun,
        output parallel_out, out_valid, overrun, bit_count
    );
endinterface

// File: rtl/sipo_frame_collector.sv
// sipo_frame_collector: gathers WIDTH serial bits into a frame held in a one-entry output buffer
module sipo_frame_collector #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1
) (
    input logic                  clk,
    input logic                  rst,
    sipo_frame_collector_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sr, sr_base, sr_next, pout;
    logic [CW-1:0]    cnt;
    logic             ov, ovr, done, load;
    assign bus.parallel_out = pout;
    assign bus.out_valid    = ov;
    assign bus.overrun      = ovr;
    assign bus.bit_count    = cnt;
    // next shift value; a sync restarts from an empty register so the new bit is the first of its frame
    always_comb begin
        sr_base = bus.sync ? '0 : sr;
        sr_next = LSB_FIRST ? {bus.serial_in, sr_base[WIDTH-1:1]} : {sr_base[WIDTH-2:0], bus.serial_in};
        done    = bus.in_valid && !bus.sync && state == COLLECT && cnt == CW'(WIDTH - 1);
        load    = done && (!ov || bus.out_ready);
    end
    // collector FSM: counts accepted bits, wraps to zero on frame completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else if (bus.in_valid) begin
            sr    <= sr_next;
            cnt   <= done ? '0 : (bus.sync ? CW'(1) : cnt + CW'(1));
            state <= done ? IDLE : COLLECT;
        end else if (bus.sync) begin
            sr    <= '0;
            cnt   <= '0;
            state <= IDLE;
        end
    end
    // output buffer: load completed frame when free or drained this cycle, else drop and flag overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pout <= '0;
            ov   <= 1'b0;
            ovr  <= 1'b0;
        end else begin
            if (load) begin
                pout <= sr_next;
                ov   <= 1'b1;
            end else if (ov && bus.out_ready) begin
                ov   <= 1'b0;
            end
            ovr <= (ovr && !bus.clr_overrun) || (done && !load);
        end
    end
endmodule

// File: tb/tb_sipo_frame_collector.sv
// tb_sipo_frame_collector: directed checks of the SIPO frame collector in both bit orders
module tb_sipo_frame_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    sipo_frame_collector_if #(.WIDTH(4)) a();
    sipo_frame_collector_if #(.WIDTH(4)) b();
    sipo_frame_collector #(.WIDTH(4), .LSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(a));
    sipo_frame_collector #(.WIDTH(4), .LSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(b));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic bi, input logic v, input logic s, input logic r, input logic c);
        a.serial_in = bi; a.in_valid = v; a.sync = s; a.out_ready = r; a.clr_overrun = c;
        b.serial_in = bi; b.in_valid = v; b.sync = s; b.out_ready = r; b.clr_overrun = c;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [3:0] first_to_last, input logic r, input logic r_last);
        for (int i = 3; i >= 0; i--) drive(first_to_last[i], 1'b1, 1'b0, i == 0 ? r_last : r, 1'b0);
    endtask
    initial begin
        a.serial_in = 0; a.in_valid = 0; a.sync = 0; a.out_ready = 0; a.clr_overrun = 0;
        b.serial_in = 0; b.in_valid = 0; b.sync = 0; b.out_ready = 0; b.clr_overrun = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ov", a.out_valid, 0);
        chk("rst_bc", a.bit_count, 0);
        chk("rst_pout", a.parallel_out, 0);
        chk("rst_ovr", a.overrun, 0);
        #3 rst = 1'b1;
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        chk("basic_bc3", a.bit_count, 3);
        chk("basic_ov_early", a.out_valid, 0);
        drive(1, 1, 0, 1, 0);
        chk("basic_ov", a.out_valid, 1);
        chk("basic_pout", a.parallel_out, 4'b1011);
        chk("basic_bc_wrap", a.bit_count, 0);
        drive(0, 0, 0, 1, 0);
        chk("basic_ov_one_cycle", a.out_valid, 0);
        chk("basic_pout_hold", a.parallel_out, 4'b1011);
        drive(1, 1, 0, 1, 0);
        drive(0, 1, 0, 1, 0);
        chk("sync_bc2", a.bit_count, 2);
        drive(0, 0, 1, 1, 0);
        chk("sync_bc0", a.bit_count, 0);
        chk("sync_no_frame", a.out_valid, 0);
        send(4'b0110, 1, 1);
        chk("sync_pout", a.parallel_out, 4'b0110);
        chk("sync_ov", a.out_valid, 1);
        drive(0, 0, 0, 1, 0);
        send(4'b1100, 0, 0);
        chk("ovr_first_ov", a.out_valid, 1);
        chk("ovr_first_pout", a.parallel_out, 4'b0011);
        chk("ovr_first_flag", a.overrun, 0);
        send(4'b1111, 0, 0);
        chk("ovr_drop_ov", a.out_valid, 1);
        chk("ovr_drop_pout", a.parallel_out, 4'b0011);
        chk("ovr_set", a.overrun, 1);
        drive(0, 0, 0, 0, 1);
        chk("ovr_clr", a.overrun, 0);
        chk("ovr_clr_ov", a.out_valid, 1);
        drive(0, 0, 0, 1, 0);
        chk("drain_ov", a.out_valid, 0);
        send(4'b1010, 0, 0);
        chk("full_pout", a.parallel_out, 4'b0101);
        send(4'b0101, 0, 1);
        chk("replace_ov", a.out_valid, 1);
        chk("replace_pout", a.parallel_out, 4'b1010);
        chk("replace_ovr", a.overrun, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(0, 1, 1, 1, 0);
        chk("syncv_bc1", a.bit_count, 1);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        chk("syncv_pout", a.parallel_out, 4'b1110);
        chk("syncv_ov", a.out_valid, 1);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        chk("arst_pre_bc", a.bit_count, 2);
        #2 rst = 1'b0;
        #1;
        chk("arst_ov", a.out_valid, 0);
        chk("arst_bc", a.bit_count, 0);
        chk("arst_pout", a.parallel_out, 0);
        #1 rst = 1'b1;
        send(4'b0011, 1, 1);
        chk("arst_new_pout", a.parallel_out, 4'b1100);
        chk("arst_new_ov", a.out_valid, 1);
        drive(0, 0, 0, 1, 0);
        send(4'b1101, 1, 1);
        chk("lsb_pout", a.parallel_out, 4'b1011);
        chk("msb_pout", b.parallel_out, 4'b1101);
        chk("msb_ov", b.out_valid, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sipo_frame_collector.md
SIPO_FRAME_COLLECTOR -- requirements
Module: sipo_frame_collector

Interface
REQ-001 Parameter WIDTH, default 4: frame length in bits, legal range 2..16.
REQ-002 Parameter LSB_FIRST, default 1: 1 = first received bit is bit 0; 0 = first received bit is bit WIDTH-1.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1: reset, asynchronous assert, active-low.
REQ-005 Port serial_in  input  1: serial data bit, sampled only when in_valid=1.
REQ-006 Port in_valid  input  1: qualifies serial_in for the current cycle.
REQ-007 Port sync  input  1: frame restart; discards any partial frame.
REQ-008 Port parallel_out  output  WIDTH: completed frame; held stable while out_valid=1.
REQ-009 Port out_valid  output  1: parallel_out holds an unconsumed frame.
REQ-010 Port out_ready  input  1: consumer accepts parallel_out when out_valid=1 and out_ready=1.
REQ-011 Port overrun  output  1: sticky flag; a completed frame was dropped.
REQ-012 Port clr_overrun  input  1: synchronous clear of overrun.
REQ-013 Port bit_count  output  $clog2(WIDTH)+1: bits collected in the current partial frame.

Function
REQ-014 Collector FSM SHALL have two states: IDLE (bit_count=0) and COLLECT (1..WIDTH-1 bits held).
- IDLE -> COLLECT on an accepted bit.
- COLLECT -> IDLE on frame completion, or on sync without in_valid.
REQ-015 Each cycle with in_valid=1 SHALL shift serial_in into the internal shift register and increment bit_count by 1.
- LSB_FIRST=1: insert at MSB, shift right.
- LSB_FIRST=0: insert at LSB, shift left.
REQ-016 A cycle with sync=1 and in_valid=0 SHALL clear bit_count to 0 and discard the partial frame; no output change.
REQ-017 A cycle with sync=1 and in_valid=1 SHALL discard the partial frame and take serial_in as the first bit of a new frame (bit_count=1 after the edge).
REQ-018 Frame completion SHALL be the in_valid cycle that brings bit_count to WIDTH; bit_count SHALL read 0 after that edge (wrap, never shows WIDTH).
REQ-019 Output buffer SHALL be one entry, states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 On completion with buffer EMPTY, or FULL with out_ready=1 in the same cycle, parallel_out SHALL load the full frame and out_valid SHALL be 1 after that same edge (latency 0 cycles after the last bit's edge).
REQ-021 On completion with buffer FULL and out_ready=0, the new frame SHALL be dropped, parallel_out/out_valid SHALL be unchanged, and overrun SHALL set.
REQ-022 out_valid=1 with out_ready=1 and no completion SHALL clear out_valid on that edge; parallel_out SHALL retain its last value.
REQ-023 parallel_out SHALL not change while out_valid=1 except by a load under REQ-020.
REQ-024 overrun SHALL stay 1 until clr_overrun=1; simultaneous set and clr_overrun SHALL leave overrun=1 (set wins).
REQ-025 Bit collection SHALL continue regardless of out_ready; the collector never stalls the upstream serializer.

Reset
REQ-026 rst=0 SHALL immediately, without a clock, force: FSM=IDLE, bit_count=0, shift register=0, parallel_out=0, out_valid=0, overrun=0.
REQ-027 rst=0 mid-frame or with out_valid=1 SHALL discard all frames; the first accepted bit after rst returns to 1 SHALL be bit 0 of a new frame.

Verification
REQ-028 WIDTH=4, LSB_FIRST=1, out_ready=1: serial bits 1,1,0,1 on four consecutive in_valid cycles -> parallel_out=4'b1011, out_valid=1 after the 4th edge for exactly one cycle.
REQ-029 Bits 1,0 then sync=1 with in_valid=0, then 0,1,1,0 -> bit_count returns to 0 at sync; parallel_out=4'b0110; no frame is emitted for the partial 1,0.
REQ-030 out_ready=0: frame 4'b0011, then frame 4'b1111 -> out_valid=1, parallel_out=4'b0011, overrun=1; clr_overrun -> overrun=0.
REQ-031 Buffer FULL with 4'b0101, out_ready=1 in the same cycle as the last bit of 4'b1010 -> after the edge out_valid=1, parallel_out=4'b1010, overrun=0.
REQ-032 rst low asynchronously after 2 bits with out_valid=1 -> out_valid=0, bit_count=0, parallel_out=0 before the next edge; then bits 0,0,1,1 -> 4'b1100.
REQ-033 LSB_FIRST=0: bits 1,1,0,1 -> parallel_out=4'b1101.
